// File: rtl/game_pkg.sv
// Shared game types and constants for the projectile drawing stage.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    HIT    = 2'd2
  } proj_state_t;

  localparam int DEF_GROUND_Y = 700;
  localparam int DEF_H_LIMIT  = 1024;

  localparam logic [11:0] RGB_GREEN = 12'h0_F_0;
  localparam logic [11:0] RGB_RED   = 12'hF_0_0;

  // Signed 13-bit add clamped to +/-4095 instead of wrapping.
  function automatic logic signed [12:0] sat_add(input logic signed [12:0] a,
                                                 input logic signed [12:0] b);
    logic signed [13:0] s;
    s = $signed({a[12], a}) + $signed({b[12], b});
    if (s > 14'sd4095)       return 13'sd4095;
    else if (s < -14'sd4095) return -13'sd4095;
    else                     return $signed(s[12:0]);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/projectile_motion.sv
// Projectile FSM: launch latch, per-frame ballistic integration with
// saturation, exit/landing detection and the HIT hold-off counter.
// Optional macro DRAW_PROJECTILE_HIT_FLASH_EN enables drawing during HIT.
module projectile_motion
  import game_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int GRAVITY    = 1,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int H_LIMIT    = DEF_H_LIMIT,
  parameter int HIT_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               fire,
  input  logic [11:0]        x0,
  input  logic [11:0]        y0,
  input  logic [11:0]        vx0,
  input  logic [11:0]        vy0,
  output logic signed [12:0] x,
  output logic signed [12:0] y,
  output proj_state_t        state,
  output logic               landed,
  output logic               draw_en,
  output logic               draw_hit
);

  localparam logic signed [12:0] GRAV     = 13'(GRAVITY);
  localparam logic signed [13:0] SIZE_S   = 14'(SIZE);
  localparam logic signed [13:0] GROUND_S = 14'(GROUND_Y);
  localparam logic signed [13:0] HLIM_S   = 14'(H_LIMIT);
  localparam logic [7:0]         HIT_LOAD = 8'(HIT_FRAMES - 1);

  logic signed [12:0] vx, vy;
  logic signed [12:0] nx, ny, nvy;
  logic signed [13:0] bottom;
  logic               exit_hit;
  logic [7:0]         hit_cnt;

  // Next position/velocity from the current (old) velocities, and exit test.
  always_comb begin
    nx       = sat_add(x, vx);
    ny       = sat_add(y, vy);
    nvy      = sat_add(vy, GRAV);
    bottom   = $signed({ny[12], ny}) + SIZE_S;
    exit_hit = (bottom >= GROUND_S) || nx[12] || ($signed({nx[12], nx}) >= HLIM_S);
  end

  // State machine and integrator, advanced only on frame ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      vx      <= '0;
      vy      <= '0;
      hit_cnt <= '0;
      landed  <= 1'b0;
    end else begin
      landed <= 1'b0;
      case (state)
        IDLE: begin
          // A tick coinciding with the launch is not consumed by the update.
          if (fire) begin
            x     <= $signed({1'b0, x0});
            y     <= $signed({1'b0, y0});
            vx    <= $signed({vx0[11], vx0});
            vy    <= $signed({vy0[11], vy0});
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (tick) begin
            x  <= nx;
            y  <= ny;
            vy <= nvy;
            if (exit_hit) begin
              state   <= HIT;
              landed  <= 1'b1;
              hit_cnt <= HIT_LOAD;
            end
          end
        end
        HIT: begin
          if (tick) begin
            if (hit_cnt == '0) state <= IDLE;
            else               hit_cnt <= hit_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Which states put the square on screen.
  always_comb begin
`ifdef DRAW_PROJECTILE_HIT_FLASH_EN
    draw_en = (state == FLIGHT) || ((state == HIT) && hit_cnt[2]);
`else
    draw_en = (state == FLIGHT);
`endif
    draw_hit = (state == HIT);
  end

endmodule

// File: rtl/draw_projectile.sv
// VGA stage: 1-cycle registered pass-through of the timing stream with a
// projectile square overlaid. Frame tick = rising edge of in.vblnk.
// Optional macro DRAW_PROJECTILE_HIT_FLASH_EN: flashing square during HIT.
module draw_projectile
  import game_pkg::*;
#(
  parameter int          SIZE       = 16,
  parameter logic [11:0] COLOR      = RGB_GREEN,
  parameter logic [11:0] HIT_COLOR  = RGB_RED,
  parameter int          GRAVITY    = 1,
  parameter int          GROUND_Y   = DEF_GROUND_Y,
  parameter int          H_LIMIT    = DEF_H_LIMIT,
  parameter int          HIT_FRAMES = 30
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        fire,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  input  logic [11:0] vx0,
  input  logic [11:0] vy0,
  output logic        busy,
  output logic        landed,
  output logic [11:0] proj_x,
  output logic [11:0] proj_y,
  vga_if.in           in,
  vga_if.out          out
);

  localparam logic signed [13:0] SIZE_S = 14'(SIZE);

  logic               vblnk_prev;
  logic               tick;
  logic signed [12:0] x, y;
  proj_state_t        state;
  logic               draw_en, draw_hit;
  logic signed [13:0] hc, vc, xs, ys;
  logic               draw;

  projectile_motion #(
    .SIZE      (SIZE),
    .GRAVITY   (GRAVITY),
    .GROUND_Y  (GROUND_Y),
    .H_LIMIT   (H_LIMIT),
    .HIT_FRAMES(HIT_FRAMES)
  ) u_motion (
    .clk     (clk60MHz),
    .rst     (rst),
    .tick    (tick),
    .fire    (fire),
    .x0      (x0),
    .y0      (y0),
    .vx0     (vx0),
    .vy0     (vy0),
    .x       (x),
    .y       (y),
    .state   (state),
    .landed  (landed),
    .draw_en (draw_en),
    .draw_hit(draw_hit)
  );

  assign tick   = in.vblnk & ~vblnk_prev;
  assign busy   = (state != IDLE);
  assign proj_x = x[12] ? '0 : x[11:0];
  assign proj_y = y[12] ? '0 : y[11:0];

  // Signed box test of the current pixel against the square.
  always_comb begin
    hc   = $signed({3'b000, in.hcount});
    vc   = $signed({3'b000, in.vcount});
    xs   = $signed({x[12], x});
    ys   = $signed({y[12], y});
    draw = draw_en && !in.hblnk && !in.vblnk &&
           (hc >= xs) && (hc < xs + SIZE_S) &&
           (vc >= ys) && (vc < ys + SIZE_S);
  end

  // Registered stream copy with overlay, plus previous vblnk for the tick.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      vblnk_prev <= in.vblnk;
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= draw ? (draw_hit ? HIT_COLOR : COLOR) : in.rgb;
    end
  end

endmodule

// File: tb/tb_draw_projectile.sv
// Self-checking bench for draw_projectile (default build, no hit flash).
module tb_draw_projectile;
  import game_pkg::*;

  localparam int T_SIZE = 16;

  logic        clk = 1'b0;
  logic        rst, fire;
  logic [11:0] x0, y0, vx0, vy0;
  logic        busy, landed;
  logic [11:0] proj_x, proj_y;

  always #8 clk = ~clk;

  vga_if vin ();
  vga_if vout ();

  draw_projectile dut (
    .clk60MHz(clk),
    .rst     (rst),
    .fire    (fire),
    .x0      (x0),
    .y0      (y0),
    .vx0     (vx0),
    .vy0     (vy0),
    .busy    (busy),
    .landed  (landed),
    .proj_x  (proj_x),
    .proj_y  (proj_y),
    .in      (vin),
    .out     (vout)
  );

  typedef struct packed {
    logic [10:0] vc;
    logic        vs;
    logic        vb;
    logic [10:0] hc;
    logic        hs;
    logic        hb;
    logic [11:0] rgb;
  } vga_t;

  typedef struct {
    logic [11:0] x0, y0, vx0, vy0;
    int          ticks;
    int          ex, ey;
    int          ebusy;
    int          elanded;
  } vec_t;

  vga_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   landed_cnt;

  // Reference model of the projectile (0 idle, 1 flight, 2 hit).
  int   m_state, mx, my, mvx, mvy, mcnt, m_landed;
  logic m_prev;

  function automatic int sext12(input logic [11:0] v);
    return v[11] ? int'(v) - 4096 : int'(v);
  endfunction

  function automatic int clampi(input int v);
    if (v > 4095)  return 4095;
    if (v < -4095) return -4095;
    return v;
  endfunction

  function automatic int near(input int c);
    int v;
    v = c - 3 + int'($urandom_range(0, 21));
    if (v < 0)    v = 0;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  function automatic logic [11:0] rand_rgb();
    logic [11:0] r;
    r = 12'($urandom);
    if (r == RGB_GREEN) r = 12'h123;
    return r;
  endfunction

  task automatic check_eq(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_state = 0; mx = 0; my = 0; mvx = 0; mvy = 0; mcnt = 0;
    m_landed = 0; m_prev = 1'b0;
  endtask

  // One clock: predict output, clock, advance model, compare.
  task automatic cycle();
    vga_t e, a;
    logic tk, drw;
    int   hc, vc, ex, ey;
    @(negedge clk);
    hc  = int'(vin.hcount);
    vc  = int'(vin.vcount);
    drw = (m_state == 1) && !vin.hblnk && !vin.vblnk &&
          hc >= mx && hc < mx + T_SIZE && vc >= my && vc < my + T_SIZE;
    if (rst) e = '0;
    else     e = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync,
                  vin.hblnk, drw ? RGB_GREEN : vin.rgb};
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      tk = vin.vblnk & ~m_prev;
      m_prev = vin.vblnk;
      m_landed = 0;
      case (m_state)
        0: if (fire) begin
             mx = int'(x0); my = int'(y0);
             mvx = sext12(vx0); mvy = sext12(vy0);
             m_state = 1;
           end
        1: if (tk) begin
             mx = clampi(mx + mvx);
             my = clampi(my + mvy);
             mvy = clampi(mvy + 1);
             if (my + T_SIZE >= DEF_GROUND_Y || mx < 0 || mx >= DEF_H_LIMIT) begin
               m_state = 2; m_landed = 1; mcnt = 29;
             end
           end
        default: if (tk) begin
             if (mcnt == 0) m_state = 0;
             else mcnt--;
           end
      endcase
    end
    #1;
    a = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync,
         vout.hblnk, vout.rgb};
    e = exp_q.pop_front();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL stream: got %h, expected %h", a, e);
    end
    if (landed === 1'b1) landed_cnt++;
    ex = (mx < 0) ? 0 : mx;
    ey = (my < 0) ? 0 : my;
    n_checks++;
    if (busy !== (m_state != 0) || landed !== (m_landed != 0) ||
        int'(proj_x) != ex || int'(proj_y) != ey) begin
      n_fail++;
      $display("FAIL status: got busy=%b landed=%b x=%0d y=%0d, expected busy=%0d landed=%0d x=%0d y=%0d",
               busy, landed, proj_x, proj_y, m_state != 0, m_landed, ex, ey);
    end
  endtask

  task automatic rand_stream(input logic vb);
    vin.vcount = 11'($urandom);
    vin.hcount = 11'($urandom);
    vin.vsync  = 1'($urandom);
    vin.hsync  = 1'($urandom);
    vin.hblnk  = 1'($urandom);
    vin.vblnk  = vb;
    vin.rgb    = rand_rgb();
  endtask

  task automatic set_pix(input int hc, input int vc, input logic [11:0] rgb);
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = rgb;
  endtask

  // One short frame: 2 blanking cycles (tick on the first) then pixels near the square.
  task automatic frame();
    for (int i = 0; i < 12; i++) begin
      vin.vsync  = 1'($urandom);
      vin.hsync  = 1'($urandom);
      vin.rgb    = rand_rgb();
      vin.hcount = 11'(near(mx));
      vin.vcount = 11'(near(my));
      if (i < 2) begin
        vin.vblnk = 1'b1;
        vin.hblnk = 1'b1;
      end else begin
        vin.vblnk = 1'b0;
        vin.hblnk = ($urandom_range(0, 4) == 0);
      end
      cycle();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_stream(1'b0);
      cycle();
    end
    rst = 1'b0;
  endtask

  task automatic launch(input logic [11:0] lx, input logic [11:0] ly,
                        input logic [11:0] lvx, input logic [11:0] lvy);
    rand_stream(1'b0);
    cycle();
    x0 = lx; y0 = ly; vx0 = lvx; vy0 = lvy;
    fire = 1'b1;
    rand_stream(1'b0);
    cycle();
    fire = 1'b0;
    landed_cnt = 0;
  endtask

  task automatic count_to_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      frame();
      n++;
    end
    check_eq(name, n, 30);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{12'd100,  12'd400, 12'd5,    12'hFF6, 1, 105,  390, 1, 0};
    vecs[1] = '{12'd100,  12'd400, 12'd5,    12'hFF6, 2, 110,  381, 1, 0};
    vecs[2] = '{12'd100,  12'd400, 12'd5,    12'hFF6, 3, 115,  373, 1, 0};
    vecs[3] = '{12'd1020, 12'd400, 12'd8,    12'd0,   1, 1028, 400, 1, 1};
    vecs[4] = '{12'd0,    12'd680, 12'd0,    12'd2,   1, 0,    682, 1, 0};
    vecs[5] = '{12'd0,    12'd680, 12'd0,    12'd2,   2, 0,    685, 1, 1};
    vecs[6] = '{12'd3,    12'd200, 12'hFFB,  12'd0,   1, 0,    200, 1, 1};
    vecs[7] = '{12'd4095, 12'd0,   12'd2047, 12'd0,   1, 4095, 0,   1, 1};
    vecs[8] = '{12'd50,   12'd60,  12'd1,    12'd1,   0, 50,   60,  1, 0};

    model_reset();
    rst = 1'b1; fire = 1'b0;
    x0 = '0; y0 = '0; vx0 = '0; vy0 = '0;
    landed_cnt = 0;
    rand_stream(1'b0);

    // Reset while streaming.
    do_reset(5);
    check_eq("reset_busy", int'(busy), 0);
    rst = 1'b1;
    rand_stream(1'b1);
    cycle();
    rst = 1'b0;
    check_eq("reset_rgb", int'(vout.rgb), 0);
    check_eq("reset_hcount", int'(vout.hcount), 0);

    // Idle pass-through with random stream; no projectile colour may appear.
    begin
      int n_col;
      n_col = 0;
      for (int i = 0; i < 40; i++) begin
        rand_stream(1'($urandom));
        cycle();
        if (vout.rgb == RGB_GREEN) n_col++;
      end
      check_eq("idle_no_color", n_col, 0);
    end

    // Table of launches.
    for (int v = 0; v < 9; v++) begin
      do_reset(3);
      launch(vecs[v].x0, vecs[v].y0, vecs[v].vx0, vecs[v].vy0);
      for (int t = 0; t < vecs[v].ticks; t++) frame();
      check_eq($sformatf("vec%0d_x", v), int'(proj_x), vecs[v].ex);
      check_eq($sformatf("vec%0d_y", v), int'(proj_y), vecs[v].ey);
      check_eq($sformatf("vec%0d_busy", v), int'(busy), vecs[v].ebusy);
      check_eq($sformatf("vec%0d_landed", v), landed_cnt, vecs[v].elanded);
    end

    // Square pixels after two ticks at (110,381).
    do_reset(3);
    launch(12'd100, 12'd400, 12'd5, 12'hFF6);
    frame(); frame();
    set_pix(110, 381, 12'h123); cycle();
    check_eq("pix_110_381", int'(vout.rgb), int'(RGB_GREEN));
    set_pix(125, 396, 12'h123); cycle();
    check_eq("pix_125_396", int'(vout.rgb), int'(RGB_GREEN));
    set_pix(126, 381, 12'h456); cycle();
    check_eq("pix_126_381", int'(vout.rgb), 12'h456);
    set_pix(110, 397, 12'h789); cycle();
    check_eq("pix_110_397", int'(vout.rgb), 12'h789);
    set_pix(109, 381, 12'h321); cycle();
    check_eq("pix_109_381", int'(vout.rgb), 12'h321);

    // Reset mid-flight: square vanishes from the next output cycle on.
    set_pix(112, 385, 12'h0AB);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_eq("midrst_rgb", int'(vout.rgb), 0);
    set_pix(112, 385, 12'h0AB); cycle();
    check_eq("midrst_after", int'(vout.rgb), 12'h0AB);
    check_eq("midrst_busy", int'(busy), 0);

    // Landing: single pulse, 30 ticks in HIT, nothing drawn there.
    do_reset(3);
    launch(12'd0, 12'd680, 12'd0, 12'd2);
    frame(); frame();
    check_eq("land_pulses", landed_cnt, 1);
    set_pix(5, 690, 12'h0CD); cycle();
    check_eq("hit_no_draw", int'(vout.rgb), 12'h0CD);
    count_to_idle("land_hit_ticks");
    check_eq("land_pulses_total", landed_cnt, 1);

    // Edge exit, then fire during HIT is ignored.
    do_reset(3);
    launch(12'd1020, 12'd400, 12'd8, 12'd0);
    frame();
    check_eq("edge_landed", landed_cnt, 1);
    x0 = 12'd10; y0 = 12'd10; vx0 = 12'd1; vy0 = 12'd1;
    fire = 1'b1; rand_stream(1'b0); cycle(); fire = 1'b0;
    check_eq("edge_fire_x", int'(proj_x), 1028);
    check_eq("edge_fire_busy", int'(busy), 1);
    count_to_idle("edge_hit_ticks");

    // Fire on the same cycle as a tick: no update until the next tick.
    do_reset(3);
    rand_stream(1'b0); cycle();
    x0 = 12'd200; y0 = 12'd300; vx0 = 12'd4; vy0 = 12'd0;
    fire = 1'b1; rand_stream(1'b1); cycle(); fire = 1'b0;
    rand_stream(1'b1); cycle();
    check_eq("tickfire_x", int'(proj_x), 200);
    check_eq("tickfire_y", int'(proj_y), 300);
    rand_stream(1'b0); cycle();
    frame();
    check_eq("tickfire_x2", int'(proj_x), 204);
    check_eq("tickfire_y2", int'(proj_y), 300);
    frame();
    check_eq("tickfire_y3", int'(proj_y), 301);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_projectile.md
Name: draw_projectile

Overview:
- VGA pipeline stage directly upstream of the mouse-cursor overlay stage. It sits between the background/sprite stages and the cursor overlay.
- On a fire pulse it launches a projectile (cat/dog throw) and integrates a ballistic trajectory once per frame.
- It overlays a solid square at the current position onto the incoming pixel stream.
- It forwards all timing signals with a fixed 1-cycle latency, so the cursor overlay sees an aligned stream.

Parameters:
- SIZE, 16, projectile square edge in pixels
- COLOR, 12'h0_F_0, projectile RGB444 colour
- HIT_COLOR, 12'hF_0_0, colour shown during HIT (optional feature only)
- GRAVITY, 1, added to vy every frame (pixels/frame²)
- GROUND_Y, 700, y at which the projectile bottom counts as landed
- H_LIMIT, 1024, x range is [0, H_LIMIT); outside this range counts as a hit
- HIT_FRAMES, 30, number of frames spent in HIT before returning to IDLE

Ports:
- clk60MHz  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- fire  in  1  one-cycle launch request
- x0  in  12  launch x (unsigned)
- y0  in  12  launch y (unsigned)
- vx0  in  12  launch x velocity, signed two's complement
- vy0  in  12  launch y velocity, signed (negative = upward)
- busy  out  1  high whenever state != IDLE
- landed  out  1  one-cycle pulse on FLIGHT->HIT
- proj_x  out  12  current x, for collision logic elsewhere
- proj_y  out  12  current y
- in  vga_if.in  -  upstream timing + rgb
- out  vga_if.out  -  downstream timing + rgb

Behaviour:
- Clock and reset: one clock, clk60MHz. rst is synchronous and active-high.
- Reset values: all out.* signals 0; busy=0; landed=0; proj_x=proj_y=0; vx=vy=0; state=IDLE; hit counter=0.
- Stream path: out.vcount, vsync, vblnk, hcount, hsync and hblnk are registered copies of in.*, 1-cycle latency. out.rgb is registered with the same 1 cycle.
- Frame tick: a 1-cycle internal pulse on the rising edge of in.vblnk, using a registered previous vblnk. Position updates happen only on the tick, so the square never tears mid-frame.
- Arithmetic: position and velocity are held as signed 13 bits internally. x+=vx and y+=vy use the old velocities, then vy+=GRAVITY. Sums saturate at ±4095 and do not wrap.
- State IDLE:
  - On fire: latch x0, y0, vx0 and vy0 (sign-extended) and go to FLIGHT.
  - fire while not IDLE is ignored.
- State FLIGHT: on each tick, update position and velocity, then go to HIT if any of these holds for the new values:
  - y+SIZE >= GROUND_Y
  - x < 0
  - x >= H_LIMIT
- On the FLIGHT->HIT transition: pulse landed for 1 cycle and load the hit counter with HIT_FRAMES-1.
- State HIT: position is frozen. The counter decrements on each tick; on a tick with counter==0, go to IDLE.
- Tick and fire in the same cycle while IDLE: the launch is taken. The first position update happens on the next tick, not the current one.
- proj_x/proj_y: the lower 12 bits of the position, clamped to 0 when negative.
- Pixel overlay: draw when all of the following hold, else out.rgb <= in.rgb:
  - state==FLIGHT
  - in.hblnk and in.vblnk both low
  - in.hcount in [x, x+SIZE) and in.vcount in [y, y+SIZE), compared as signed
  - When drawing, out.rgb <= COLOR.
- Reset mid-flight: returns to IDLE on the next edge. Nothing is drawn from the following output cycle onward.

Optional Feature:
- Macro: DRAW_PROJECTILE_HIT_FLASH_EN.
- Defined: during HIT, the square is drawn at the frozen position in HIT_COLOR, and alternates on/off every 4 frames (hit counter bit 2).
- Undefined: nothing is drawn in HIT; HIT only delays re-arm.

Decomposition:
- Package (game_pkg): the proj_state_t enum {IDLE, FLIGHT, HIT}, the default constants GROUND_Y and H_LIMIT, and the RGB444 colour constants.
- Sub-module projectile_motion: FSM, tick-driven integrator, saturation and hit counter. Outputs x, y, state and landed.
- draw_projectile keeps the vga_if pipeline, frame-tick detection and the overlay compare.

Test Plan:
- Reset check: assert rst for 5 cycles while streaming -> all out.* = 0, busy = 0, state IDLE.
- Pass-through: IDLE state, random in.* stream -> out.* equals in.* delayed exactly 1 cycle. No COLOR pixels appear.
- Launch and integration:
  - Stimulus: fire with x0=100, y0=400, vx0=5, vy0=-10, GRAVITY=1.
  - After tick 1: (105, 390), vy = -9. After tick 2: (110, 381).
  - The pixel at hcount=110, vcount=381 is COLOR; the pixel at hcount=126 is in.rgb.
- Landing:
  - Stimulus: y0=680, vy0=2, SIZE=16, GROUND_Y=700.
  - Tick 1: y=682, bottom 698, stays in FLIGHT. Tick 2: y=685, bottom 701, goes to HIT.
  - landed is a 1-cycle pulse; busy stays high for 30 further ticks, then IDLE.
- Edge exit: x0=1020, vx0=8 -> HIT on the first tick (x=1028 >= H_LIMIT). A fire pulse during HIT is ignored and busy is unaffected.
- Flash feature: with DRAW_PROJECTILE_HIT_FLASH_EN, the HIT square shows HIT_COLOR for 4 frames, then is absent for 4 frames. Without the macro, no square is drawn in HIT.
